// File: rtl/rv32i_dmem_responder_if.sv
// CPU <-> data-memory bus for rv32i_dmem_responder.
// Request flags are levels sampled only in IDLE; completion is a one-cycle mem_ready pulse qualified by mem_fault.
interface rv32i_dmem_responder_if;
    logic [31:0] memory_address;
    logic [31:0] to_memory;
    logic        memload_flag;
    logic        memstore_flag;
    logic [2:0]  func3;
    logic [31:0] from_memory;
    logic        mem_ready;
    logic        mem_fault;

    modport master (
        output memory_address, to_memory, memload_flag, memstore_flag, func3,
        input  from_memory, mem_ready, mem_fault
    );

    modport slave (
        input  memory_address, to_memory, memload_flag, memstore_flag, func3,
        output from_memory, mem_ready, mem_fault
    );
endinterface

// File: rtl/rv32i_dmem_responder.sv
// RV32I data-memory responder: byte-lane storage behind an IDLE/WAIT/RESP FSM with fixed latency.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned H/W accesses into faults instead of aligning them.
module rv32i_dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                         sys_clk,
    input  logic                         sys_reset,
    rv32i_dmem_responder_if.slave        bus,
    output logic [1:0]                   dbg_state_o
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [2:0]      f3_q, f3_d;
    logic            store_q, store_d;
    logic            fault_q, fault_d;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            req, f3_legal, misalign, out_of_range, req_fault;
    logic [AW+1:0]   req_addr;
    logic [AW+1:0]   acc_addr;
    logic [2:0]      acc_f3;
    logic [31:0]     acc_wdata;
    logic            acc_store, acc_fault, enter_resp, commit_we;
    logic [3:0]      be;
    logic [31:0]     wlanes, rword, ext;
    logic [7:0]      rbyte;
    logic [15:0]     rhalf;

    // Decode of the request currently on the bus.
    always_comb begin
        req      = bus.memload_flag | bus.memstore_flag;
        req_addr = bus.memory_address[AW+1:0];
        misalign = 1'b0;
        case (bus.func3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
            default:                                f3_legal = 1'b0;
        endcase
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = ((bus.func3[1:0] == 2'b01) && bus.memory_address[0]) ||
                   ((bus.func3[1:0] == 2'b10) && (bus.memory_address[1:0] != 2'b00));
`else
        if (bus.func3[1:0] == 2'b01) begin
            req_addr[0] = 1'b0;
        end else if (bus.func3[1:0] == 2'b10) begin
            req_addr[1:0] = 2'b00;
        end
`endif
        out_of_range = {2'b00, bus.memory_address[31:2]} >= 32'(DEPTH_WORDS);
        req_fault    = (bus.memload_flag & bus.memstore_flag) | ~f3_legal | out_of_range | misalign;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        store_d = store_q;
        fault_d = fault_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = req_addr;
                    wdata_d = bus.to_memory;
                    f3_d    = bus.func3;
                    store_d = bus.memstore_flag;
                    fault_d = req_fault;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states the commit happens on the accepting edge, so use the live request then.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_addr  = req_addr;
            acc_f3    = bus.func3;
            acc_wdata = bus.to_memory;
            acc_store = bus.memstore_flag;
            acc_fault = req_fault;
        end else begin
            acc_addr  = addr_q;
            acc_f3    = f3_q;
            acc_wdata = wdata_q;
            acc_store = store_q;
            acc_fault = fault_q;
        end
        enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
        commit_we  = enter_resp & acc_store & ~acc_fault;

        case (acc_f3[1:0])
            2'b00:   begin be = 4'b0001 << acc_addr[1:0];          wlanes = {4{acc_wdata[7:0]}};  end
            2'b01:   begin be = 4'b0011 << {acc_addr[1], 1'b0};    wlanes = {2{acc_wdata[15:0]}}; end
            default: begin be = 4'b1111;                           wlanes = acc_wdata;            end
        endcase

        rword = mem[acc_addr[AW+1:2]];
        rbyte = rword[8*acc_addr[1:0] +: 8];
        rhalf = acc_addr[1] ? rword[31:16] : rword[15:0];
        case (acc_f3)
            3'b000:  ext = {{24{rbyte[7]}}, rbyte};
            3'b100:  ext = {24'd0, rbyte};
            3'b001:  ext = {{16{rhalf[15]}}, rhalf};
            3'b101:  ext = {16'd0, rhalf};
            default: ext = rword;
        endcase
        rdata_d = (enter_resp && !acc_store && !acc_fault) ? ext : 32'd0;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            f3_q    <= 3'd0;
            store_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            f3_q    <= f3_d;
            store_q <= store_d;
            fault_q <= fault_d;
        end
    end

    // Storage is never cleared; a reset on the commit edge discards the store.
    always_ff @(posedge sys_clk) begin
        if (!sys_reset && commit_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[acc_addr[AW+1:2]][8*i +: 8] <= wlanes[8*i +: 8];
                end
            end
        end
    end

    assign bus.from_memory = rdata_q;
    assign bus.mem_ready   = (state_q == S_RESP);
    assign bus.mem_fault   = (state_q == S_RESP) && fault_q;
    assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Self-checking bench for rv32i_dmem_responder: directed scenarios plus randomized accesses against a byte-array model.
module tb_rv32i_dmem_responder;
    logic       clk = 1'b0;
    logic       rst1 = 1'b1;
    logic       rst3 = 1'b1;
    logic [1:0] dbg1, dbg3;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] ref_mem [0:4095];

    rv32i_dmem_responder_if if1();
    rv32i_dmem_responder_if if3();

    rv32i_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut1 (
        .sys_clk(clk), .sys_reset(rst1), .bus(if1.slave), .dbg_state_o(dbg1));
    rv32i_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) dut3 (
        .sys_clk(clk), .sys_reset(rst3), .bus(if3.slave), .dbg_state_o(dbg3));

    always #5 clk = ~clk;

    function automatic void model_access(input bit ld, input bit st, input logic [2:0] f3,
                                         input logic [31:0] a, input logic [31:0] d,
                                         output logic [31:0] exp_d, output bit exp_f);
        int size;
        logic [31:0] ea, v;
        bit legal, mis_fault;
        legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        ea = a;
        mis_fault = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        mis_fault = (a % size) != 0;
`else
        ea = a - (a % size);
`endif
        exp_f = (ld && st) || !legal || (a / 4 >= 1024) || mis_fault;
        exp_d = 32'd0;
        if (!exp_f) begin
            if (st) begin
                for (int i = 0; i < size; i++) ref_mem[ea + i] = d[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < size; i++) v = v | ({24'd0, ref_mem[ea + i]} << (8 * i));
                if (f3[2] == 1'b0 && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
                exp_d = v;
            end
        end
    endfunction

    task automatic run(input int sel, input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic rf, output int lat);
        bit got;
        @(negedge clk);
        if (sel == 0) begin
            if1.memload_flag = ld; if1.memstore_flag = st; if1.func3 = f3;
            if1.memory_address = a; if1.to_memory = d;
        end else begin
            if3.memload_flag = ld; if3.memstore_flag = st; if3.func3 = f3;
            if3.memory_address = a; if3.to_memory = d;
        end
        @(posedge clk);
        #1;
        if1.memload_flag = 1'b0; if1.memstore_flag = 1'b0;
        if3.memload_flag = 1'b0; if3.memstore_flag = 1'b0;
        got = 1'b0; rd = 32'd0; rf = 1'b0; lat = 0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if ((sel == 0) ? if1.mem_ready : if3.mem_ready) begin
                got = 1'b1;
                lat = k;
                rd  = (sel == 0) ? if1.from_memory : if3.from_memory;
                rf  = (sel == 0) ? if1.mem_fault : if3.mem_fault;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL ready_timeout: got no mem_ready within 40 cycles, expected a pulse (addr %h)", a);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 6;
        if (if1.mem_ready !== 1'b0)    begin failures++; $display("FAIL reset_ready1: got %b expected 0", if1.mem_ready); end
        if (if1.mem_fault !== 1'b0)    begin failures++; $display("FAIL reset_fault1: got %b expected 0", if1.mem_fault); end
        if (if1.from_memory !== 32'd0) begin failures++; $display("FAIL reset_data1: got %h expected 0", if1.from_memory); end
        if (if3.mem_ready !== 1'b0)    begin failures++; $display("FAIL reset_ready3: got %b expected 0", if3.mem_ready); end
        if (if3.mem_fault !== 1'b0)    begin failures++; $display("FAIL reset_fault3: got %b expected 0", if3.mem_fault); end
        if (if3.from_memory !== 32'd0) begin failures++; $display("FAIL reset_data3: got %h expected 0", if3.from_memory); end
        rst1 = 1'b0;
        rst3 = 1'b0;
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic rf; int lat;
        run(0, 0, 1, 3'd2, 32'h10, 32'hDEAD_BEEF, rd, rf, lat);
        checks += 3;
        if (lat !== 2)      begin failures++; $display("FAIL sw_latency: got %0d expected 2", lat); end
        if (rf !== 1'b0)    begin failures++; $display("FAIL sw_fault: got %b expected 0", rf); end
        if (rd !== 32'd0)   begin failures++; $display("FAIL sw_data: got %h expected 0", rd); end
        @(negedge clk);
        checks++;
        if (if1.mem_ready !== 1'b0) begin failures++; $display("FAIL ready_pulse_width: got %b expected 0", if1.mem_ready); end
        run(0, 1, 0, 3'd2, 32'h10, 32'd0, rd, rf, lat);
        checks += 3;
        if (lat !== 2)            begin failures++; $display("FAIL lw_latency: got %0d expected 2", lat); end
        if (rf !== 1'b0)          begin failures++; $display("FAIL lw_fault: got %b expected 0", rf); end
        if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_data: got %h expected deadbeef", rd); end
        @(negedge clk);
        checks++;
        if (if1.from_memory !== 32'd0) begin failures++; $display("FAIL data_after_resp: got %h expected 0", if1.from_memory); end
    endtask

    task automatic test_subword_loads();
        logic [2:0]  f3  [4];
        logic [31:0] adr [4];
        logic [31:0] exp [4];
        logic [31:0] rd; logic rf; int lat;
        f3[0] = 3'b000; adr[0] = 32'h13; exp[0] = 32'hFFFF_FFDE;
        f3[1] = 3'b100; adr[1] = 32'h13; exp[1] = 32'h0000_00DE;
        f3[2] = 3'b001; adr[2] = 32'h10; exp[2] = 32'hFFFF_BEEF;
        f3[3] = 3'b101; adr[3] = 32'h12; exp[3] = 32'h0000_DEAD;
        for (int i = 0; i < 4; i++) begin
            run(0, 1, 0, f3[i], adr[i], 32'd0, rd, rf, lat);
            checks += 2;
            if (rd !== exp[i]) begin failures++; $display("FAIL subword_load%0d: got %h expected %h", i, rd, exp[i]); end
            if (rf !== 1'b0)   begin failures++; $display("FAIL subword_fault%0d: got %b expected 0", i, rf); end
        end
    endtask

    task automatic test_byte_store();
        logic [31:0] rd; logic rf; int lat;
        run(0, 0, 1, 3'd0, 32'h11, 32'h0000_0055, rd, rf, lat);
        checks++;
        if (rf !== 1'b0) begin failures++; $display("FAIL sb_fault: got %b expected 0", rf); end
        run(0, 1, 0, 3'd2, 32'h10, 32'd0, rd, rf, lat);
        checks++;
        if (rd !== 32'hDEAD_55EF) begin failures++; $display("FAIL sb_merge: got %h expected dead55ef", rd); end
    endtask

    task automatic test_faults();
        logic [31:0] rd; logic rf; int lat;
        run(0, 1, 0, 3'd2, 32'h1000, 32'd0, rd, rf, lat);
        checks += 3;
        if (rf !== 1'b1)  begin failures++; $display("FAIL range_fault: got %b expected 1", rf); end
        if (rd !== 32'd0) begin failures++; $display("FAIL range_data: got %h expected 0", rd); end
        if (lat !== 2)    begin failures++; $display("FAIL range_latency: got %0d expected 2", lat); end
        run(0, 1, 0, 3'b011, 32'h10, 32'd0, rd, rf, lat);
        checks++;
        if (rf !== 1'b1) begin failures++; $display("FAIL func3_fault: got %b expected 1", rf); end
        run(0, 0, 1, 3'd2, 32'h0, 32'h1122_3344, rd, rf, lat);
        run(0, 1, 1, 3'd2, 32'h0, 32'hFFFF_FFFF, rd, rf, lat);
        checks++;
        if (rf !== 1'b1) begin failures++; $display("FAIL both_flags_fault: got %b expected 1", rf); end
        run(0, 1, 0, 3'd2, 32'h0, 32'd0, rd, rf, lat);
        checks++;
        if (rd !== 32'h1122_3344) begin failures++; $display("FAIL both_flags_nowrite: got %h expected 11223344", rd); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; logic rf; int lat;
        run(0, 1, 0, 3'd2, 32'h12, 32'd0, rd, rf, lat);
        checks += 2;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (rf !== 1'b1)  begin failures++; $display("FAIL lw_misalign_fault: got %b expected 1", rf); end
        if (rd !== 32'd0) begin failures++; $display("FAIL lw_misalign_data: got %h expected 0", rd); end
`else
        if (rf !== 1'b0)          begin failures++; $display("FAIL lw_misalign_fault: got %b expected 0", rf); end
        if (rd !== 32'hDEAD_55EF) begin failures++; $display("FAIL lw_misalign_data: got %h expected dead55ef", rd); end
`endif
        run(0, 1, 0, 3'd1, 32'h11, 32'd0, rd, rf, lat);
        checks++;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (rf !== 1'b1) begin failures++; $display("FAIL lh_misalign_fault: got %b expected 1", rf); end
`else
        if (rd !== 32'h0000_55EF) begin failures++; $display("FAIL lh_misalign_data: got %h expected 000055ef", rd); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic rf; int lat;
        logic [3:0] seen;
        @(negedge clk);
        if1.memstore_flag = 1'b1; if1.func3 = 3'd2;
        if1.memory_address = 32'h40; if1.to_memory = 32'hA5A5_0001;
        @(negedge clk);
        seen[0] = if1.mem_ready;
        if1.to_memory = 32'hBAD0_BAD0;
        @(negedge clk);
        seen[1] = if1.mem_ready;
        if1.memory_address = 32'h44; if1.to_memory = 32'h5A5A_0002;
        @(negedge clk);
        seen[2] = if1.mem_ready;
        @(negedge clk);
        @(negedge clk);
        seen[3] = if1.mem_ready;
        if1.memstore_flag = 1'b0;
        checks++;
        if (seen !== 4'b1010) begin failures++; $display("FAIL b2b_ready_pattern: got %b expected 1010", seen); end
        run(0, 1, 0, 3'd2, 32'h40, 32'd0, rd, rf, lat);
        checks++;
        if (rd !== 32'hA5A5_0001) begin failures++; $display("FAIL b2b_first_word: got %h expected a5a50001", rd); end
        run(0, 1, 0, 3'd2, 32'h44, 32'd0, rd, rf, lat);
        checks++;
        if (rd !== 32'h5A5A_0002) begin failures++; $display("FAIL b2b_second_word: got %h expected 5a5a0002", rd); end
    endtask

    task automatic test_wait_abort();
        logic [31:0] rd; logic rf; int lat;
        int pulses;
        run(1, 0, 1, 3'd2, 32'h20, 32'hCAFE_F00D, rd, rf, lat);
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL ws3_latency: got %0d expected 4", lat); end
        pulses = 0;
        @(negedge clk);
        if3.memstore_flag = 1'b1; if3.func3 = 3'd2;
        if3.memory_address = 32'h20; if3.to_memory = 32'h1234_5678;
        @(posedge clk);
        #1 if3.memstore_flag = 1'b0;
        @(negedge clk);
        if (if3.mem_ready) pulses++;
        @(negedge clk);
        if (if3.mem_ready) pulses++;
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        checks++;
        if (if3.from_memory !== 32'd0) begin failures++; $display("FAIL abort_data: got %h expected 0", if3.from_memory); end
        repeat (6) begin
            @(negedge clk);
            if (if3.mem_ready) pulses++;
        end
        checks++;
        if (pulses !== 0) begin failures++; $display("FAIL abort_no_ready: got %0d pulses expected 0", pulses); end
        run(1, 1, 0, 3'd2, 32'h20, 32'd0, rd, rf, lat);
        checks += 2;
        if (rd !== 32'hCAFE_F00D) begin failures++; $display("FAIL abort_old_data: got %h expected cafef00d", rd); end
        if (lat !== 4)            begin failures++; $display("FAIL abort_lw_latency: got %0d expected 4", lat); end
    endtask

    task automatic test_random();
        logic [2:0]  ltab [5];
        logic [31:0] rd, a, d, exp_d;
        logic [2:0]  f3;
        logic rf;
        bit ld, st, exp_f;
        int lat, kind, r;
        ltab[0] = 3'd0; ltab[1] = 3'd1; ltab[2] = 3'd2; ltab[3] = 3'd4; ltab[4] = 3'd5;
        for (int w = 0; w < 16; w++) begin
            a = 32'h100 + 32'(4 * w);
            d = $urandom;
            model_access(1'b0, 1'b1, 3'd2, a, d, exp_d, exp_f);
            run(0, 0, 1, 3'd2, a, d, rd, rf, lat);
            checks++;
            if (rf !== 1'b0) begin failures++; $display("FAIL rand_prefill_fault: got %b expected 0 at %h", rf, a); end
        end
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 19);
            ld = (kind == 0) || (kind > 8);
            st = (kind <= 8);
            if (st && !ld) begin
                r  = $urandom_range(0, 7);
                f3 = (r < 7) ? 3'(r % 3) : 3'd3;
            end else begin
                r  = $urandom_range(0, 11);
                f3 = (r < 10) ? ltab[r % 5] : ((r == 10) ? 3'd3 : 3'd6);
            end
            a = ($urandom_range(0, 15) == 0) ? (32'h1000 + 32'($urandom_range(0, 255)))
                                             : (32'h100 + 32'($urandom_range(0, 63)));
            d = $urandom;
            model_access(ld, st, f3, a, d, exp_d, exp_f);
            run(0, ld, st, f3, a, d, rd, rf, lat);
            checks += 3;
            if (rf !== exp_f) begin failures++; $display("FAIL rand_fault[%0d]: got %b expected %b (f3 %0d addr %h)", n, rf, exp_f, f3, a); end
            if (rd !== exp_d) begin failures++; $display("FAIL rand_data[%0d]: got %h expected %h (f3 %0d addr %h)", n, rd, exp_d, f3, a); end
            if (lat !== 2)    begin failures++; $display("FAIL rand_latency[%0d]: got %0d expected 2", n, lat); end
        end
    endtask

    initial begin
        if1.memory_address = 32'd0; if1.to_memory = 32'd0; if1.func3 = 3'd0;
        if1.memload_flag = 1'b0; if1.memstore_flag = 1'b0;
        if3.memory_address = 32'd0; if3.to_memory = 32'd0; if3.func3 = 3'd0;
        if3.memload_flag = 1'b0; if3.memstore_flag = 1'b0;
        test_reset();
        test_store_load();
        test_subword_loads();
        test_byte_store();
        test_faults();
        test_misalign();
        test_back_to_back();
        test_wait_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
